// File: rtl/frequency_counter_max7219_pkg.sv
// Shared constants, frame table and BCD helpers
// for the gated frequency counter and its MAX7219 driver.
package frequency_counter_max7219_pkg;

  localparam logic [3:0] REG_DIGIT1    = 4'h1;
  localparam logic [3:0] REG_DIGIT8    = 4'h8;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCAN      = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_TEST      = 4'hF;

  localparam logic [3:0] CODEB_DASH = 4'hA;
  localparam int         FRAME_LEN  = 34;
  localparam logic [2:0] INIT_LAST  = 3'd5;

  typedef enum logic [1:0] {
    SEQ_INIT,
    SEQ_IDLE,
    SEQ_REFRESH
  } seq_state_t;

  function automatic logic [15:0] mk_frame(
    input logic [3:0] a,
    input logic [7:0] d
  );
    return {4'h0, a, d};
  endfunction

  function automatic logic [15:0] init_frame(
    input logic [2:0] i,
    input logic [3:0] inten
  );
    logic [15:0] f;
    case (i)
      3'd0:    f = mk_frame(REG_SHUTDOWN, 8'h00);
      3'd1:    f = mk_frame(REG_DECODE, 8'hFF);
      3'd2:    f = mk_frame(REG_INTENSITY, {4'h0, inten});
      3'd3:    f = mk_frame(REG_SCAN, 8'h07);
      3'd4:    f = mk_frame(REG_TEST, 8'h00);
      default: f = mk_frame(REG_SHUTDOWN, 8'h01);
    endcase
    return f;
  endfunction

  // Returns {carry_out, incremented 8-digit BCD value}
  function automatic logic [32:0] bcd_inc(
    input logic [31:0] v
  );
    logic [31:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return {c, r};
  endfunction

endpackage

// File: rtl/frequency_counter_max7219_frame_tx.sv
// Serializes one 16-bit MAX7219 frame, MSB first,
// in a fixed 34-cycle slot; accepts a new frame in its last cycle.
module max7219_frame_tx
  import frequency_counter_max7219_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [15:0] i_data,
  output logic        o_busy,
  output logic        o_clko,
  output logic        o_dout,
  output logic        o_load
);

  logic        r_busy;
  logic [5:0]  r_cnt;
  logic [15:0] r_data;
  logic        r_clko;
  logic        r_dout;
  logic        r_load;
  logic        w_last;
  logic        w_accept;
  logic [5:0]  w_nxt;
  logic [3:0]  w_bit;

  assign w_last   = r_busy && (r_cnt == 6'(FRAME_LEN - 1));
  assign o_busy   = r_busy && !w_last;
  assign w_accept = i_start && !o_busy;
  assign w_nxt    = r_cnt + 6'd1;
  assign w_bit    = 4'd15 - w_nxt[4:1];

  assign o_clko = r_clko;
  assign o_dout = r_dout;
  assign o_load = r_load;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= 1'b0;
      r_cnt  <= 6'd0;
      r_data <= 16'h0000;
      r_clko <= 1'b0;
      r_dout <= 1'b0;
      r_load <= 1'b1;
    end else if (w_accept) begin
      r_busy <= 1'b1;
      r_cnt  <= 6'd0;
      r_data <= i_data;
      r_clko <= 1'b0;
      r_dout <= i_data[15];
      r_load <= 1'b0;
    end else if (w_last) begin
      r_busy <= 1'b0;
      r_clko <= 1'b0;
      r_dout <= 1'b0;
      r_load <= 1'b1;
    end else if (r_busy) begin
      r_cnt <= w_nxt;
      if (w_nxt < 6'd32) begin
        r_clko <= w_nxt[0];
        r_load <= 1'b0;
        // data moves only on the low half of each bit
        if (!w_nxt[0]) r_dout <= r_data[w_bit];
      end else begin
        r_clko <= 1'b0;
        r_dout <= 1'b0;
        r_load <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/frequency_counter_max7219.sv
// Gated BCD frequency counter showing its result
// on a MAX7219 8-digit display.
module frequency_counter_max7219
  import frequency_counter_max7219_pkg::*;
#(
  parameter logic [27:0] RESET_VALUE_DIV2 = 28'd50_000_000,
  parameter logic [3:0]  INTENSITY        = 4'h8
) (
  input  logic clk,
  input  logic reset,
  input  logic iclk,
  output logic clko,
  output logic dout,
  output logic load
);

  logic        r_s1, r_s2, r_s3;
  logic        r_pre;
  logic [27:0] r_timer;
  logic [31:0] r_bcd;
  logic        r_ovf;
  logic [31:0] r_disp;
  seq_state_t  r_state;
  logic [2:0]  r_idx;
  logic        r_start;
  logic [15:0] r_data;
  logic        r_pend;

  logic        w_rise;
  logic [32:0] w_inc;
  logic [31:0] w_bcd_nxt;
  logic        w_gate;
  logic        w_busy;
  logic        w_accept;
  logic [3:0]  w_addr;

  function automatic logic [15:0] digit_frame(
    input logic [31:0] d,
    input logic [2:0]  i
  );
    logic [2:0] p;
    p = 3'd7 - i;
    return mk_frame(REG_DIGIT8 - {1'b0, i},
                    {4'h0, d[{p, 2'b00} +: 4]});
  endfunction

  assign w_rise    = r_s2 & ~r_s3;
  assign w_inc     = bcd_inc(r_bcd);
  assign w_bcd_nxt = w_rise ? w_inc[31:0] : r_bcd;
  assign w_gate    = r_pre && (r_timer == 28'd1);
  assign w_accept  = r_start && !w_busy;
  assign w_addr    = REG_DIGIT8 - {1'b0, r_idx};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_pre   <= 1'b0;
      r_timer <= 28'd0;
      r_bcd   <= 32'd0;
      r_ovf   <= 1'b0;
      r_disp  <= 32'd0;
    end else begin
      r_s1  <= iclk;
      r_s2  <= r_s1;
      r_s3  <= r_s2;
      r_pre <= ~r_pre;
      // a zero timer (after reset) loads one short so window 0 is 2N long
      if (r_pre) begin
        if (r_timer == 28'd1)
          r_timer <= RESET_VALUE_DIV2;
        else if (r_timer == 28'd0)
          r_timer <= RESET_VALUE_DIV2 - 28'd1;
        else
          r_timer <= r_timer - 28'd1;
      end
      if (w_gate) begin
        r_disp <= r_ovf ? {8{CODEB_DASH}} : r_bcd;
        r_bcd  <= w_rise ? 32'd1 : 32'd0;
        r_ovf  <= 1'b0;
      end else begin
        r_bcd <= w_bcd_nxt;
        if (w_rise && w_inc[32]) r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SEQ_INIT;
      r_idx   <= 3'd0;
      r_start <= 1'b0;
      r_data  <= 16'h0000;
      r_pend  <= 1'b0;
    end else begin
      unique case (r_state)
        SEQ_INIT: begin
          if (!r_start) begin
            r_start <= 1'b1;
            r_data  <= init_frame(r_idx, INTENSITY);
          end else if (w_accept) begin
            if (r_idx == INIT_LAST) begin
              r_start <= 1'b0;
              r_idx   <= 3'd0;
              r_state <= SEQ_IDLE;
            end else begin
              r_idx  <= r_idx + 3'd1;
              r_data <= init_frame(r_idx + 3'd1, INTENSITY);
            end
          end
        end
        SEQ_IDLE: begin
          if (r_pend) begin
            r_pend  <= 1'b0;
            r_idx   <= 3'd0;
            r_start <= 1'b1;
            r_data  <= digit_frame(r_disp, 3'd0);
            r_state <= SEQ_REFRESH;
          end
        end
        SEQ_REFRESH: begin
          if (w_accept) begin
            if (w_addr == REG_DIGIT1) begin
              r_start <= 1'b0;
              r_idx   <= 3'd0;
              r_state <= SEQ_IDLE;
            end else begin
              r_idx  <= r_idx + 3'd1;
              r_data <= digit_frame(r_disp, r_idx + 3'd1);
            end
          end
        end
        default: r_state <= SEQ_INIT;
      endcase
      // set after the case so a same-cycle gate is never lost
      if (w_gate) r_pend <= 1'b1;
    end
  end

  max7219_frame_tx u_tx (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_start (r_start),
    .i_data  (r_data),
    .o_busy  (w_busy),
    .o_clko  (clko),
    .o_dout  (dout),
    .o_load  (load)
  );

endmodule

// File: tb/tb_frequency_counter_max7219.sv
// Bench for frequency_counter_max7219: random edge bursts per
// gate window, decoded MAX7219 frames checked against a count model.
module tb_frequency_counter_max7219;

  localparam int WIN = 512;
  localparam int NW  = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic iclk  = 1'b0;
  logic clko;
  logic dout;
  logic load;

  int n_pass  = 0;
  int n_total = 0;

  int frames[$];
  int fbits[$];
  int flow[$];
  int exp_val[$];

  logic [15:0] m_word;
  int          m_bits;
  int          m_low;
  bit          m_in;

  int init_tab[6] = '{'h0C00, 'h09FF, 'h0A08,
                      'h0B07, 'h0F00, 'h0C01};

  frequency_counter_max7219 #(
    .RESET_VALUE_DIV2 (28'd256),
    .INTENSITY        (4'h8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .iclk  (iclk),
    .clko  (clko),
    .dout  (dout),
    .load  (load)
  );

  always #5 clk = ~clk;

  // Frame decoder: one bit per clko-high cycle, frame ends on load high
  always @(negedge clk) begin
    if (!reset) begin
      m_in   = 1'b0;
      m_bits = 0;
      m_low  = 0;
      m_word = 16'h0;
    end else if (load === 1'b0) begin
      m_in  = 1'b1;
      m_low = m_low + 1;
      if (clko === 1'b1) begin
        m_word = {m_word[14:0], dout};
        m_bits = m_bits + 1;
      end
    end else if (m_in) begin
      frames.push_back(int'(m_word));
      fbits.push_back(m_bits);
      flow.push_back(m_low);
      m_in   = 1'b0;
      m_bits = 0;
      m_low  = 0;
      m_word = 16'h0;
    end
  end

  // Expected digit frame j (register 8-j) for a window total v
  function automatic int exp_frame(input int v, input int j);
    int p;
    int dig;
    p = 1;
    for (int k = 0; k < 7 - j; k++) p = p * 10;
    dig = (v > 99999999) ? 10 : (v / p) % 10;
    return ((8 - j) << 8) | dig;
  endfunction

  function automatic int frame_at(input int i);
    return (i < frames.size()) ? frames[i] : -1;
  endfunction

  // One full gate window of e pulses (h high, l low cycles)
  task automatic run_window(input int e, input int h,
                            input int l, input bit preset);
    for (int i = 0; i < WIN; i++) begin
      iclk = (i >= 20) && ((i - 20) < e * (h + l)) &&
             (((i - 20) % (h + l)) < h);
      if (preset && i == 10) force dut.r_bcd = 32'h9999_9990;
      if (preset && i == 12) release dut.r_bcd;
      @(negedge clk);
    end
    iclk = 1'b0;
    exp_val.push_back(preset ? 99999990 + e : e);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_total++;
    if (clko !== 1'b0)
      $display("FAIL reset_clko got %b want 0", clko);
    else n_pass++;
    n_total++;
    if (dout !== 1'b0)
      $display("FAIL reset_dout got %b want 0", dout);
    else n_pass++;
    n_total++;
    if (load !== 1'b1)
      $display("FAIL reset_load got %b want 1", load);
    else n_pass++;
  endtask

  task automatic test_windows;
    int e, h, l;
    for (int w = 0; w < NW; w++) begin
      e = (w == 1) ? 100 : int'($urandom_range(0, 90));
      h = (w == 1) ? 1 : int'($urandom_range(1, 2));
      l = (w == 1) ? 1 : int'($urandom_range(1, 2));
      run_window(e, h, l, 1'b0);
    end
    run_window(0, 1, 1, 1'b0);
  endtask

  task automatic test_init_frames(input string tag);
    for (int i = 0; i < 6; i++) begin
      n_total++;
      if (frame_at(i) !== init_tab[i])
        $display("FAIL %s_init%0d got %h want %h",
                 tag, i, frame_at(i), init_tab[i]);
      else n_pass++;
    end
    for (int i = 0; i < 6 && i < fbits.size(); i++) begin
      n_total++;
      if (fbits[i] !== 16 || flow[i] !== 32)
        $display("FAIL %s_shape%0d got %0d bits/%0d low want 16/32",
                 tag, i, fbits[i], flow[i]);
      else n_pass++;
    end
  endtask

  task automatic test_refresh;
    int want;
    n_total++;
    if (frames.size() !== 6 + 8 * NW)
      $display("FAIL refresh_count got %0d want %0d",
               frames.size(), 6 + 8 * NW);
    else n_pass++;
    for (int w = 0; w < NW; w++) begin
      for (int j = 0; j < 8; j++) begin
        want = exp_frame(exp_val[w], j);
        n_total++;
        if (frame_at(6 + 8 * w + j) !== want)
          $display("FAIL win%0d_dig%0d got %h want %h", w,
                   8 - j, frame_at(6 + 8 * w + j), want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_overflow;
    int want;
    int base;
    run_window(20, 1, 2, 1'b1);
    run_window(int'($urandom_range(1, 90)), 2, 1, 1'b0);
    run_window(0, 1, 1, 1'b0);
    n_total++;
    if (frames.size() !== 6 + 8 * (NW + 3))
      $display("FAIL ovf_count got %0d want %0d",
               frames.size(), 6 + 8 * (NW + 3));
    else n_pass++;
    for (int w = NW; w < NW + 3; w++) begin
      base = 6 + 8 * w;
      for (int j = 0; j < 8; j++) begin
        want = exp_frame(exp_val[w], j);
        n_total++;
        if (frame_at(base + j) !== want)
          $display("FAIL ovf_win%0d_dig%0d got %h want %h", w,
                   8 - j, frame_at(base + j), want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_midframe_reset;
    int n;
    n = 0;
    while (!(load === 1'b0 && clko === 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    n_total++;
    if (n >= 2000)
      $display("FAIL midframe_wait got timeout want frame");
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (load !== 1'b1 || clko !== 1'b0 || dout !== 1'b0)
      $display("FAIL midframe_async got l%b c%b d%b want l1 c0 d0",
               load, clko, dout);
    else n_pass++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    frames.delete();
    fbits.delete();
    flow.delete();
    repeat (240) @(negedge clk);
    n_total++;
    if (frames.size() !== 6)
      $display("FAIL replay_count got %0d want 6", frames.size());
    else n_pass++;
    test_init_frames("replay");
  endtask

  initial begin
    test_reset();
    reset = 1'b1;
    test_windows();
    test_init_frames("boot");
    test_refresh();
    test_overflow();
    test_midframe_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
